hdmi_pixel_fetch: RTL and testbench
===================================

# hdmi_pixel_fetch

Frame-buffer fetch stage directly upstream of the HDMI output core. It issues burst reads from video memory into a show-ahead pixel FIFO and presents the head word on `color`. The core pops words with `read_fifo`, and frame and line pacing come from the core's `read_go`, `read_next_line` and `read_done` pulses. The block keeps the FIFO filled ahead of active video and at most two lines ahead of the display.

## Interface
- `NUM_BYTES_PER_PIXEL`, 4, 4 = RGB888 (one pixel per word), 2 = RGB565 (two pixels per word)
- `HRES`, 1280, active pixels per line
- `VRES`, 720, active lines per frame
- `FB_BASE`, 32'h0000_0000, byte address of pixel (0,0); word aligned
- `FIFO_DEPTH`, 256, FIFO words; power of two, at least 2*`BURST_WORDS`
- `BURST_WORDS`, 64, words per memory request; must divide `WPL`
- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `read_go`  in  1  one-cycle pulse; start of frame
- `read_next_line`  in  1  one-cycle pulse; the display advanced one line
- `read_done`  in  1  one-cycle pulse; end of frame
- `read_fifo`  in  1  pop the head word this cycle
- `color`  out  32  FIFO head word
- `mem_req`  out  1  read request valid
- `mem_addr`  out  32  request byte address
- `mem_len`  out  8  request length in words, always `BURST_WORDS`
- `mem_ack`  in  1  request accepted this cycle
- `mem_rdata`  in  32  read beat data
- `mem_rvalid`  in  1  read beat valid
- `fifo_level`  out  log2(`FIFO_DEPTH`)+1  current FIFO occupancy
- `underrun`  out  1  sticky; set when a pop occurs with the FIFO empty

## Operation
- `WPL` = `HRES`*`NUM_BYTES_PER_PIXEL`/4 words per line. `WPF` = `WPL`*`VRES`.
- The FSM has four states: IDLE, REQ, DATA, DRAIN.
- IDLE: on `read_go`, flush the FIFO, set `addr` to `FB_BASE`, clear `words_fetched`, `fetch_line` and `show_line`, then go to REQ.
- REQ: the request launches when all of the following hold:
  - free space minus in-flight words is at least `BURST_WORDS`;
  - `fetch_line` < `show_line`+2;
  - `words_fetched` < `WPF`.
- During a launched request, `mem_req`=1 with `mem_addr`=`addr`, held stable until `mem_ack`. Then go to DATA.
- DATA: push each `mem_rvalid` beat. After `BURST_WORDS` beats:
  - `addr` += 4*`BURST_WORDS`, and `words_fetched` += `BURST_WORDS`;
  - `fetch_line` increments when `words_fetched` crosses a multiple of `WPL`;
  - go to REQ, or to IDLE if `words_fetched`=`WPF`.
- `read_next_line` increments `show_line`, saturating at `VRES`.
- `read_done`: in REQ, go to IDLE. In DATA, go to DRAIN.
- `read_go` while not IDLE: in REQ or DATA, go to DRAIN, then restart as from IDLE once the burst completes.
- DRAIN: accept and discard the remaining beats of the outstanding burst. At the last beat, restart if a `read_go` is pending, otherwise go to IDLE.
- Pop rules:
  - `read_fifo` with the FIFO non-empty advances the read pointer.
  - `read_fifo` with the FIFO empty leaves the pointer unchanged and sets `underrun`.
  - `underrun` clears only on `reset` or `read_go`.
- Simultaneous push and pop in one cycle: the level is unchanged.
- Beats are never dropped outside DRAIN, because in-flight accounting guarantees space.

## Timing
- Reset values:
  - outputs: `mem_req`=0, `mem_addr`=`FB_BASE`, `mem_len`=`BURST_WORDS`, `color`=0, `fifo_level`=0, `underrun`=0;
  - FSM in IDLE.
- `color` is show-ahead, with zero-cycle read latency. A beat pushed into an empty FIFO at edge N appears on `color` after edge N.
- A pop at edge N presents the next word after edge N.
- When empty, `color` holds the last popped word (0 after flush or reset).
- `mem_req` rises no earlier than the cycle after entry to REQ. It falls the cycle after `mem_ack`.
- `read_go`/`read_done` take effect at the edge where they are sampled high. A `reset` at any time aborts all activity, including DRAIN, with no beat accounting kept.

## Configuration
- Macro: `HDMI_PIXEL_FETCH_UNDERRUN_FILL_EN`.
- Defined: while `underrun` is set, `color` is forced to 32'hFF00FF00 (magenta in RGB888) until the next `read_go`, making starvation visible on screen.
- Undefined: `color` always shows the FIFO head or held value. `underrun` still reports.

## Structure
- Shared package `hdmi_pkg`:
  - the FSM state enum;
  - `WPL`/`WPF` derivation functions;
  - the `FB_BASE` default and the magenta fill constant.
- Sub-module `hdmi_pixel_fifo`: synchronous show-ahead FIFO with depth parameter and a level output. The FSM, address and line counters remain in the top.

## Test plan
- Frame fetch, `HRES`=640, `VRES`=4, `NUM_BYTES_PER_PIXEL`=4, `read_go` then continuous `mem_ack` → 40 requests at `FB_BASE`+256*k; the fetch stops at 2 lines ahead until `read_next_line`.
- Backpressure: `read_fifo` held low → requests cease at `fifo_level`=256, with exactly 4 bursts issued. Then pop 64 → exactly one new request.
- Underrun: pop on empty after `read_go` → `underrun`=1 next cycle. The macro defined gives `color`=32'hFF00FF00; the macro undefined leaves `color`=0.
- Mid-burst `read_go` after 10 of 64 beats → 54 beats discarded, `fifo_level`=0, next `mem_addr`=`FB_BASE`.
- RGB565, `HRES`=1280 → `WPL`=640; alternate-cycle pops drain one word per two pixels, with the data order preserved.
- `reset` during DATA → all outputs at reset values the next cycle, and no request until `read_go`.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types and helpers for the HDMI frame-buffer fetch path.
// State encoding, line/frame word counts and fill colour live here.
package hdmi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN
  } state_t;

  localparam logic [31:0] FB_BASE_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] FILL_COLOR      = 32'hFF00_FF00;

  function automatic int calc_wpl(int hres, int bpp);
    return hres * bpp / 4;
  endfunction

  function automatic int calc_wpf(int hres, int bpp, int vres);
    return calc_wpl(hres, bpp) * vres;
  endfunction

endpackage

// File: rtl/hdmi_pixel_fifo.sv
// Synchronous show-ahead FIFO; head is valid with zero read latency.
// When empty, head holds the last popped word (0 after flush/reset).
module hdmi_pixel_fifo #(
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              wdata,
  input  logic                     pop,
  output logic [31:0]              head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [31:0]   held;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (level != FULL);
  assign head    = empty ? held : mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      held  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr <= rptr + 1'b1;
        held <= mem[rptr];
      end
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/hdmi_pixel_fetch.sv
// Burst fetch from video memory into the pixel FIFO, two lines ahead max.
// HDMI_PIXEL_FETCH_UNDERRUN_FILL_EN: force magenta on color while underrun.
module hdmi_pixel_fetch
  import hdmi_pkg::*;
#(
  parameter int          NUM_BYTES_PER_PIXEL = 4,
  parameter int          HRES                = 1280,
  parameter int          VRES                = 720,
  parameter logic [31:0] FB_BASE             = FB_BASE_DEFAULT,
  parameter int          FIFO_DEPTH          = 256,
  parameter int          BURST_WORDS         = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          read_go,
  input  logic                          read_next_line,
  input  logic                          read_done,
  input  logic                          read_fifo,
  output logic [31:0]                   color,
  output logic                          mem_req,
  output logic [31:0]                   mem_addr,
  output logic [7:0]                    mem_len,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_rvalid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int WPL = calc_wpl(HRES, NUM_BYTES_PER_PIXEL);
  localparam int WPF = calc_wpf(HRES, NUM_BYTES_PER_PIXEL, VRES);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BW  = $clog2(BURST_WORDS) + 1;

  localparam logic [31:0]   WPL_L   = 32'(WPL);
  localparam logic [31:0]   WPF_L   = 32'(WPF);
  localparam logic [31:0]   BURST_L = 32'(BURST_WORDS);
  localparam logic [31:0]   STEP_L  = 32'(4 * BURST_WORDS);
  localparam logic [15:0]   VRES_L  = 16'(VRES);
  localparam logic [BW-1:0] BURST_B = BW'(BURST_WORDS);
  localparam logic [BW-1:0] LAST_B  = BW'(BURST_WORDS - 1);
  localparam logic [LW-1:0] DEPTH_V = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] BURST_V = LW'(BURST_WORDS);

  state_t        state;
  state_t        state_nx;
  logic [31:0]   addr;
  logic [31:0]   words_fetched;
  logic [31:0]   line_words;
  logic [15:0]   fetch_line;
  logic [15:0]   show_line;
  logic [BW-1:0] beats;
  logic [BW-1:0] inflight;
  logic          go_pending;
  logic          req;
  logic          underrun_r;

  logic          restart;
  logic          accepted;
  logic          beat;
  logic          last_beat;
  logic          burst_done;
  logic          frame_end;
  logic          space_ok;
  logic          launch;
  logic [LW-1:0] free;
  logic [31:0]   head;
  logic          fifo_empty;

  assign accepted   = req && mem_ack;
  assign beat       = mem_rvalid && (state == DATA || state == DRAIN);
  assign last_beat  = beat && (beats == LAST_B);
  assign burst_done = (state == DATA) && last_beat;
  assign frame_end  = (words_fetched + BURST_L == WPF_L);
  assign free       = DEPTH_V - fifo_level;
  assign space_ok   = free >= BURST_V + LW'(inflight);

  assign launch = (state == REQ) && !req &&
                  !read_go && !read_done && space_ok &&
                  (fetch_line < show_line + 16'd2) &&
                  (words_fetched < WPF_L);

  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    unique case (state)
      IDLE: begin
        if (read_go) begin
          restart  = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        // An accepted request still owes a burst, so it must drain.
        if (read_go) begin
          if (accepted) state_nx = DRAIN;
          else begin
            restart  = 1'b1;
            state_nx = REQ;
          end
        end else if (read_done) begin
          state_nx = accepted ? DRAIN : IDLE;
        end else if (accepted) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (burst_done) begin
          if (read_go) begin
            restart  = 1'b1;
            state_nx = REQ;
          end else if (read_done || frame_end) begin
            state_nx = IDLE;
          end else begin
            state_nx = REQ;
          end
        end else if (read_go || read_done) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (last_beat) begin
          if (read_go || go_pending) begin
            restart  = 1'b1;
            state_nx = REQ;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= FB_BASE;
      words_fetched <= '0;
      line_words    <= '0;
      fetch_line    <= '0;
      show_line     <= '0;
      beats         <= '0;
      inflight      <= '0;
      go_pending    <= 1'b0;
      req           <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      state <= state_nx;

      if (restart) go_pending <= 1'b0;
      else if (read_go && state != IDLE) go_pending <= 1'b1;

      if (read_go) underrun_r <= 1'b0;
      else if (read_fifo && fifo_empty) underrun_r <= 1'b1;

      if (restart) begin
        addr          <= FB_BASE;
        words_fetched <= '0;
        line_words    <= '0;
        fetch_line    <= '0;
        show_line     <= '0;
        beats         <= '0;
        inflight      <= '0;
        req           <= 1'b0;
      end else begin
        if (read_next_line && show_line < VRES_L)
          show_line <= show_line + 16'd1;

        if (launch) req <= 1'b1;
        else if (accepted || state_nx != REQ) req <= 1'b0;

        if (accepted) begin
          beats    <= '0;
          inflight <= BURST_B;
        end else if (beat) begin
          beats    <= beats + 1'b1;
          inflight <= inflight - 1'b1;
        end

        if (burst_done) begin
          addr          <= addr + STEP_L;
          words_fetched <= words_fetched + BURST_L;
          if (line_words + BURST_L == WPL_L) begin
            line_words <= '0;
            fetch_line <= fetch_line + 16'd1;
          end else begin
            line_words <= line_words + BURST_L;
          end
        end
      end
    end
  end

  hdmi_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (restart),
    .push  ((state == DATA) && mem_rvalid),
    .wdata (mem_rdata),
    .pop   (read_fifo),
    .head  (head),
    .level (fifo_level),
    .empty (fifo_empty)
  );

  assign mem_req  = req;
  assign mem_addr = addr;
  assign mem_len  = 8'(BURST_WORDS);
  assign underrun = underrun_r;

`ifdef HDMI_PIXEL_FETCH_UNDERRUN_FILL_EN
  assign color = underrun_r ? FILL_COLOR : head;
`else
  assign color = head;
`endif

endmodule

// File: tb/tb_hdmi_pixel_fetch.sv
// Directed bench for hdmi_pixel_fetch: RGB888 640x4 and RGB565 1280x4.
// Memory returns word index (byte address / 4) as pixel data.
module tb_hdmi_pixel_fetch;

  localparam logic [31:0] A_BASE = 32'h0010_0000;
  localparam logic [31:0] B_BASE = 32'h0000_2000;
`ifdef HDMI_PIXEL_FETCH_UNDERRUN_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        a_go = 0, a_nl = 0, a_done = 0, a_pop = 0;
  logic [31:0] a_color, a_addr, a_rdata = 0;
  logic        a_req, a_ack = 1, a_rvalid = 0, a_ur;
  logic [7:0]  a_len;
  logic [8:0]  a_lvl;

  logic        b_go = 0, b_nl = 0, b_done = 0, b_pop = 0;
  logic [31:0] b_color, b_addr, b_rdata = 0;
  logic        b_req, b_ack = 1, b_rvalid = 0, b_ur;
  logic [7:0]  b_len;
  logic [8:0]  b_lvl;

  int n_checks = 0;
  int n_errors = 0;

  logic auto_pop = 0, man_pop = 0, chk_en = 0, b_ph = 0;
  int a_rem = 0, a_nreq = 0, b_rem = 0, b_nreq = 0;
  int unsigned a_next = 0, a_exp = 0, b_next = 0, b_exp = 0;
  logic [31:0] a_addrs[$];

  hdmi_pixel_fetch #(
    .NUM_BYTES_PER_PIXEL(4), .HRES(640), .VRES(4),
    .FB_BASE(A_BASE), .FIFO_DEPTH(256), .BURST_WORDS(64)
  ) dut_a (
    .clock(clock), .reset(reset), .read_go(a_go),
    .read_next_line(a_nl), .read_done(a_done),
    .read_fifo(a_pop), .color(a_color), .mem_req(a_req),
    .mem_addr(a_addr), .mem_len(a_len), .mem_ack(a_ack),
    .mem_rdata(a_rdata), .mem_rvalid(a_rvalid),
    .fifo_level(a_lvl), .underrun(a_ur)
  );

  hdmi_pixel_fetch #(
    .NUM_BYTES_PER_PIXEL(2), .HRES(1280), .VRES(4),
    .FB_BASE(B_BASE), .FIFO_DEPTH(256), .BURST_WORDS(64)
  ) dut_b (
    .clock(clock), .reset(reset), .read_go(b_go),
    .read_next_line(b_nl), .read_done(b_done),
    .read_fifo(b_pop), .color(b_color), .mem_req(b_req),
    .mem_addr(b_addr), .mem_len(b_len), .mem_ack(b_ack),
    .mem_rdata(b_rdata), .mem_rvalid(b_rvalid),
    .fifo_level(b_lvl), .underrun(b_ur)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Memory model A: accepts on req&ack, streams 64 beats next cycle on.
  always @(negedge clock) begin
    if (reset) begin
      a_rem    = 0;
      a_rvalid = 1'b0;
    end else begin
      if (a_rem > 0) begin
        a_rvalid = 1'b1;
        a_rdata  = a_next;
        a_next++;
        a_rem--;
      end else begin
        a_rvalid = 1'b0;
      end
      if (a_req && a_ack) begin
        a_rem  = 64;
        a_next = a_addr >> 2;
        a_nreq++;
        a_addrs.push_back(a_addr);
        if (a_addr == A_BASE) a_exp = A_BASE >> 2;
      end
    end
    a_pop = auto_pop ? (a_lvl != 0) : man_pop;
    if (a_pop && chk_en && a_lvl != 0) begin
      check("a_data", a_color, a_exp);
      a_exp++;
    end
  end

  // Memory model B plus alternate-cycle popping.
  always @(negedge clock) begin
    if (reset) begin
      b_rem    = 0;
      b_rvalid = 1'b0;
    end else begin
      if (b_rem > 0) begin
        b_rvalid = 1'b1;
        b_rdata  = b_next;
        b_next++;
        b_rem--;
      end else begin
        b_rvalid = 1'b0;
      end
      if (b_req && b_ack) begin
        b_rem  = 64;
        b_next = b_addr >> 2;
        b_nreq++;
        if (b_addr == B_BASE) b_exp = B_BASE >> 2;
      end
    end
    b_ph  = ~b_ph;
    b_pop = b_ph && (b_lvl != 0);
    if (b_pop) begin
      check("b_data", b_color, b_exp);
      b_exp++;
    end
  end

  int n0;
  int i0;

  initial begin
    tick(3);
    reset = 1'b0;
    check("rst_req", 32'(a_req), 32'd0);
    check("rst_addr", a_addr, A_BASE);
    check("rst_len", 32'(a_len), 32'd64);
    check("rst_color", a_color, 32'd0);
    check("rst_level", 32'(a_lvl), 32'd0);
    check("rst_underrun", 32'(a_ur), 32'd0);
    tick(10);
    check("no_req_before_go", 32'(a_nreq), 32'd0);

    // Full frame, popping continuously.
    n0 = a_nreq;
    i0 = a_addrs.size();
    auto_pop = 1'b1;
    chk_en   = 1'b1;
    a_go = 1'b1; tick(1); a_go = 1'b0;
    for (int i = 0; i < 4000 && a_nreq - n0 < 20; i++) tick(1);
    tick(300);
    check("two_lines_ahead", 32'(a_nreq - n0), 32'd20);
    check("drained", 32'(a_lvl), 32'd0);
    a_nl = 1'b1; tick(1); a_nl = 1'b0;
    tick(1500);
    check("line_adv_1", 32'(a_nreq - n0), 32'd30);
    a_nl = 1'b1; tick(1); a_nl = 1'b0;
    tick(1500);
    check("frame_reqs", 32'(a_nreq - n0), 32'd40);
    check("addr_0", a_addrs[i0], A_BASE);
    check("addr_1", a_addrs[i0+1], A_BASE + 32'd256);
    check("addr_39", a_addrs[i0+39], A_BASE + 32'd9984);
    check("frame_words", a_exp, (A_BASE >> 2) + 32'd2560);
    a_nl = 1'b1; tick(1); a_nl = 1'b0;
    tick(200);
    check("frame_end_reqs", 32'(a_nreq - n0), 32'd40);
    check("frame_end_req", 32'(a_req), 32'd0);
    a_done = 1'b1; tick(1); a_done = 1'b0;

    // Backpressure: no pops.
    auto_pop = 1'b0;
    n0 = a_nreq;
    a_go = 1'b1; tick(1); a_go = 1'b0;
    tick(600);
    check("bp_reqs", 32'(a_nreq - n0), 32'd4);
    check("bp_level", 32'(a_lvl), 32'd256);
    check("bp_req_low", 32'(a_req), 32'd0);
    man_pop = 1'b1; tick(64); man_pop = 1'b0;
    tick(300);
    check("bp_one_more", 32'(a_nreq - n0), 32'd5);
    check("bp_level2", 32'(a_lvl), 32'd256);
    check("bp_popped", a_exp, (A_BASE >> 2) + 32'd64);

    // Underrun: pop on empty right after read_go.
    chk_en = 1'b0;
    a_done = 1'b1; tick(1); a_done = 1'b0;
    tick(2);
    a_go = 1'b1; tick(1); a_go = 1'b0;
    man_pop = 1'b1; tick(1); man_pop = 1'b0;
    check("ur_set", 32'(a_ur), 32'd1);
    check("ur_color", a_color, FILL ? 32'hFF00_FF00 : 32'h0);
    for (int i = 0; i < 200 && a_lvl == 0; i++) tick(1);
    tick(1);
    check("ur_sticky", 32'(a_ur), 32'd1);
    check("ur_head", a_color,
          FILL ? 32'hFF00_FF00 : (A_BASE >> 2));

    // Reset while beats stream in.
    for (int i = 0; i < 200 && a_lvl < 5; i++) tick(1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("rr_req", 32'(a_req), 32'd0);
    check("rr_addr", a_addr, A_BASE);
    check("rr_level", 32'(a_lvl), 32'd0);
    check("rr_color", a_color, 32'd0);
    check("rr_underrun", 32'(a_ur), 32'd0);
    n0 = a_nreq;
    tick(100);
    check("rr_no_req", 32'(a_nreq - n0), 32'd0);

    // read_go mid-burst.
    n0 = a_nreq;
    chk_en = 1'b1;
    a_go = 1'b1; tick(1); a_go = 1'b0;
    for (int i = 0; i < 300 && a_lvl != 9; i++) @(negedge clock);
    a_go = 1'b1;
    @(posedge clock); #1;
    a_go = 1'b0;
    check("mid_pushed", 32'(a_lvl), 32'd10);
    for (int i = 0; i < 200 && a_rem != 0; i++) tick(1);
    check("mid_flushed", 32'(a_lvl), 32'd0);
    for (int i = 0; i < 50 && !a_req; i++) tick(1);
    check("mid_restart_addr", a_addr, A_BASE);
    check("mid_reqs", 32'(a_nreq - n0), 32'd1);
    auto_pop = 1'b1;
    tick(400);
    check("mid_reqs2", 32'(a_nreq - n0) > 32'd1 ? 32'd1 : 32'd0, 32'd1);
    check("mid_data_flow", a_exp > (A_BASE >> 2) + 32'd64 ? 32'd1 : 32'd0, 32'd1);

    // RGB565: 640 words per line, stall after two lines.
    b_go = 1'b1; tick(1); b_go = 1'b0;
    for (int i = 0; i < 6000 && b_exp != (B_BASE >> 2) + 1280; i++) tick(1);
    tick(200);
    check("b_reqs", 32'(b_nreq), 32'd20);
    check("b_words", b_exp, (B_BASE >> 2) + 32'd1280);
    check("b_level", 32'(b_lvl), 32'd0);
    check("b_underrun", 32'(b_ur), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
